// File: rtl/oq_sched_pkg.sv
// Shared types and word-layout helpers for the output-queue round-robin scheduler.
// A FIFO word is {tlast, tkeep, tdata}, with tdata at the LSB end.
package oq_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int TDATA_LSB = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int word_width(input int dw);
        return dw + dw / 8 + 1;
    endfunction

    function automatic int tkeep_lsb(input int dw);
        return dw;
    endfunction

    function automatic int tlast_bit(input int dw);
        return dw + dw / 8;
    endfunction

endpackage

// File: rtl/oq_rr_pick.sv
// Combinational rotate-priority picker: first requesting queue strictly after last_ptr,
// wrapping modulo NUM_QUEUES, so the last served queue has the lowest priority.
module oq_rr_pick #(
    parameter int NUM_QUEUES = 5,
    parameter int IDX_W      = 3
) (
    input  logic [NUM_QUEUES-1:0] req_i,
    input  logic [IDX_W-1:0]      last_ptr_i,
    output logic [IDX_W-1:0]      grant_o,
    output logic                  valid_o
);

    logic [IDX_W-1:0] idx;

    // Scan from farthest to nearest so the nearest requester is the final assignment.
    always_comb begin
        grant_o = '0;
        idx     = '0;
        valid_o = |req_i;
        for (int k = NUM_QUEUES; k >= 1; k--) begin
            idx = IDX_W'((int'(last_ptr_i) + k) % NUM_QUEUES);
            if (req_i[idx]) grant_o = idx;
        end
    end

endmodule

// File: rtl/oq_rr_scheduler.sv
// Packet-granular round-robin drain of fallthrough FIFOs onto one AXI4-Stream master.
// Define OQ_SCHED_STATS_EN to add per-queue 32-bit accepted-packet counters (pkt_count).
module oq_rr_scheduler
    import oq_sched_pkg::*;
#(
    parameter int NUM_QUEUES = 5,
    parameter int DATA_WIDTH = 256,
    parameter int QID_WIDTH  = 3
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [NUM_QUEUES-1:0]                                 q_empty,
    input  logic [NUM_QUEUES*(DATA_WIDTH+DATA_WIDTH/8+1)-1:0]     q_dout,
    output logic [NUM_QUEUES-1:0]                                 q_rd_en,
    input  logic [NUM_QUEUES-1:0]                                 queue_en,
    output logic [DATA_WIDTH-1:0]                                 m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]                               m_axis_tkeep,
    output logic                                                  m_axis_tlast,
    output logic                                                  m_axis_tvalid,
    input  logic                                                  m_axis_tready,
    output logic [QID_WIDTH-1:0]                                  m_axis_tqid
`ifdef OQ_SCHED_STATS_EN
    ,
    output logic [NUM_QUEUES*32-1:0]                              pkt_count
`endif
);

    localparam int WW       = word_width(DATA_WIDTH);
    localparam int KW       = DATA_WIDTH / 8;
    localparam int IW       = clog2(NUM_QUEUES);
    localparam int KEEP_LSB = tkeep_lsb(DATA_WIDTH);
    localparam int LAST_BIT = tlast_bit(DATA_WIDTH);

    state_e                        state_q;
    logic [IW-1:0]                 grant_q;
    logic [IW-1:0]                 last_ptr_q;
    logic [IW-1:0]                 sel;
    logic [IW-1:0]                 pick_grant;
    logic                          pick_vld;
    logic                          accept;
    logic [NUM_QUEUES-1:0]         req;
    logic [NUM_QUEUES-1:0][WW-1:0] heads;
    logic [WW-1:0]                 head;

    // Reset forces the output view onto queue 0 immediately, before the edge lands.
    assign sel   = reset ? '0 : grant_q;
    assign heads = q_dout;
    assign head  = heads[sel];
    assign req   = ~q_empty & queue_en;

    assign m_axis_tdata  = head[TDATA_LSB +: DATA_WIDTH];
    assign m_axis_tkeep  = head[KEEP_LSB +: KW];
    assign m_axis_tlast  = head[LAST_BIT];
    assign m_axis_tqid   = QID_WIDTH'(sel);
    assign m_axis_tvalid = !reset && (state_q == SEND) && !q_empty[sel];
    assign accept        = m_axis_tvalid && m_axis_tready;

    always_comb begin
        q_rd_en      = '0;
        q_rd_en[sel] = accept;
    end

    oq_rr_pick #(
        .NUM_QUEUES (NUM_QUEUES),
        .IDX_W      (IW)
    ) u_pick (
        .req_i      (req),
        .last_ptr_i (last_ptr_q),
        .grant_o    (pick_grant),
        .valid_o    (pick_vld)
    );

    // Grant is held through underruns; only an accepted tlast releases it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_ptr_q <= IW'(NUM_QUEUES - 1);
        end else begin
            case (state_q)
                IDLE: if (pick_vld) begin
                    grant_q <= pick_grant;
                    state_q <= SEND;
                end
                SEND: if (accept && m_axis_tlast) begin
                    last_ptr_q <= grant_q;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

`ifdef OQ_SCHED_STATS_EN
    logic [NUM_QUEUES-1:0][31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else if (accept && m_axis_tlast) cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
    end

    assign pkt_count = cnt_q;
`endif

endmodule

// File: doc/oq_rr_scheduler.md
Name: oq_rr_scheduler

Overview:
- Packet-granular round-robin scheduler for the output-queue stage.
- Drains NUM_QUEUES fallthrough FIFOs, whose words are {tlast, tkeep, tdata}, onto one AXI4-Stream master.
- Each granted queue holds the output until its tlast beat is accepted.
- A register-driven enable mask selects which queues may be granted.

Parameters:
- NUM_QUEUES, 5: number of FIFO queues; range 2..16.
- DATA_WIDTH, 256: tdata width in bits; must be a multiple of 8.
- QID_WIDTH, 3: width of the queue-id output; must satisfy 2**QID_WIDTH >= NUM_QUEUES.
- Derived, not overridable: WORD_WIDTH = DATA_WIDTH + DATA_WIDTH/8 + 1.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- q_empty  in  NUM_QUEUES  per-queue FIFO empty.
- q_dout  in  NUM_QUEUES*WORD_WIDTH  flattened fallthrough FIFO heads; queue i occupies [i*WORD_WIDTH +: WORD_WIDTH].
- q_rd_en  out  NUM_QUEUES  per-queue FIFO read strobe.
- queue_en  in  NUM_QUEUES  grant eligibility mask from the register block.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  DATA_WIDTH/8  output byte enables.
- m_axis_tlast  out  1  end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tqid  out  QID_WIDTH  index of the granted queue.
- pkt_count  out  NUM_QUEUES*32  per-queue packet counters; present only with OQ_SCHED_STATS_EN.

Behaviour:
- Reset (synchronous, active-high; takes effect at the next clk edge):
  - state = IDLE, grant = 0.
  - last_ptr = NUM_QUEUES-1, so the first grant goes to q0.
  - All counters are cleared.
  - Output values during and after reset: m_axis_tvalid = 0, q_rd_en = 0, m_axis_tqid = 0; tdata/tkeep/tlast are the head word of queue 0.
- States: IDLE and SEND.
- IDLE:
  - req = ~q_empty & queue_en.
  - If req != 0, grant = the first set bit of req, scanning upward from last_ptr+1 modulo NUM_QUEUES. The next state is SEND.
  - If req == 0, the block stays in IDLE.
  - m_axis_tvalid = 0 throughout IDLE, giving one arbitration bubble per packet.
- SEND:
  - m_axis_tvalid = ~q_empty[grant].
  - Data and tqid are driven combinationally from q_dout[grant] and grant.
  - q_rd_en[grant] = m_axis_tvalid & m_axis_tready. All other q_rd_en bits are 0.
  - The path from tready to rd_en is combinational; there is no extra register stage.
  - When a beat is accepted with tlast = 1: last_ptr <= grant and the next state is IDLE.
- Mid-packet underrun: if the granted queue goes empty, tvalid drops and the grant is held. No other queue may interleave.
- queue_en only affects arbitration. Deasserting it during SEND does not abort the current packet.
- Handshake rule: while tvalid = 1 and tready = 0, tdata/tkeep/tlast/tqid stay stable. This follows from the fallthrough head being stable when rd_en = 0.
- Fairness: a queue that has just been served is the lowest priority at the next arbitration. With every queue active, service is strict rotation 0,1,...,N-1,0.
- Single-beat packet (tlast on the first beat): the block occupies 2 cycles, IDLE then SEND.
- Reset during SEND abandons the packet. Downstream must tolerate a truncated packet; FIFOs are reset alongside this block.

Optional Feature:
- Macro: OQ_SCHED_STATS_EN.
- Defined:
  - Adds the pkt_count port.
  - Counter i increments by 1 on each accepted tlast beat from queue i.
  - Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Counters are cleared by reset.
- Undefined: the port and the counters are absent. Scheduling behaviour is identical.

Decomposition:
- Package oq_sched_pkg:
  - state encoding (IDLE = 0, SEND = 1);
  - WORD_WIDTH derivation;
  - bit offsets of the tlast/tkeep/tdata fields within a word;
  - a clog2 helper.
- Sub-module oq_rr_pick:
  - purely combinational rotate-priority picker;
  - inputs: req[NUM_QUEUES] and last_ptr;
  - outputs: grant index and valid.
- The FSM, mux and counters stay in oq_rr_scheduler.

Test Plan:
- Reset then idle: all q_empty = 1, queue_en = all 1s → tvalid = 0 and q_rd_en = 0 for 20 cycles.
- Rotation: queues 0, 2 and 4 each hold two 3-beat packets, tready = 1 → tqid sequence 0,0,0,2,2,2,4,4,4,0,0,0,2,2,2,4,4,4, with a 1-cycle gap between packets.
- Backpressure: tready toggles 1010…, 4-beat packet on q1 → each beat is held stable while tready = 0, and rd_en pulses exactly 4 times.
- Underrun and mask: q3 goes empty after beat 2 of 5 while q0 is nonempty → tvalid drops, grant stays on q3, and q0 is not served until q3's tlast. Clearing queue_en[3] mid-packet does not abort it; q3 is not granted afterwards.
- Single-beat packets: q0 and q1 each hold ten 1-beat packets → alternating tqid 0,1,0,1,…, each packet 2 cycles apart.
- With OQ_SCHED_STATS_EN: 7 packets from q2 → pkt_count[2] = 7, all others 0. Preloading a counter to 0xFFFFFFFF then sending 1 packet → 0. Asserting reset → all counters 0.
